// File: rtl/riscv_trace_buffer.sv
// Trace-capture buffer for the single-cycle RISC-V core.
// Circular pre-trigger window, post-trigger tail, then frozen readout.
module riscv_trace_buffer #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int CTRL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_in,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [XLEN-1:0]            alu_in,
  input  logic [CTRL_W-1:0]          ctrl_in,
  input  logic                       arm,
  input  logic                       trig_en,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic                       force_trig,
  input  logic [$clog2(DEPTH)-1:0]   post_cnt,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CTRL_W+2*XLEN-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       triggered
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = CTRL_W + 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   remain_q, remain_d;
  logic            trig_q, trig_d;
  logic            we;
  logic            hit;
  logic [CW-1:0]   cnt_inc;
  logic [DW-1:0]   mem_q [DEPTH];

  assign hit     = valid_in && (force_trig || (trig_en && pc_in == trig_pc));
  assign cnt_inc = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    remain_d = remain_q;
    trig_d   = trig_q;
    we       = 1'b0;
    if (arm) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      remain_d = '0;
      trig_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          if (valid_in) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = cnt_inc;
            if (hit) begin
              trig_d = 1'b1;
              if (post_cnt == '0) begin
                state_d = S_DONE;
              end else begin
                remain_d = post_cnt;
                state_d  = S_POST;
              end
            end
          end
        end
        S_POST: begin
          if (valid_in) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = cnt_inc;
            remain_d = remain_q - 1'b1;
            if (remain_q == AW'(1)) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (rd_valid && rd_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    // A full buffer gives wr_ptr - DEPTH == wr_ptr, the oldest slot.
    if (state_d == S_DONE && state_q != S_DONE)
      rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      remain_q <= '0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      remain_q <= remain_d;
      trig_q   <= trig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= {ctrl_in, alu_in, pc_in};
  end

  assign rd_valid  = (state_q == S_DONE) && (count_q != '0);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign state     = state_q;
  assign triggered = trig_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: scenario table plus hand sequences,
// with a queue model of the expected buffer contents.
module tb_riscv_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] alu_in = '0;
  logic [15:0] ctrl_in = '0;
  logic        arm = 1'b0;
  logic        trig_en = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        force_trig = 1'b0;
  logic [2:0]  post_cnt = '0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [79:0] rd_data;
  logic [3:0]  count;
  logic [1:0]  state;
  logic        triggered;

  riscv_trace_buffer #(.XLEN(32), .DEPTH(8), .CTRL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pc_in(pc_in),
    .alu_in(alu_in), .ctrl_in(ctrl_in), .arm(arm), .trig_en(trig_en),
    .trig_pc(trig_pc), .force_trig(force_trig), .post_cnt(post_cnt),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .state(state), .triggered(triggered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ten;
    logic [31:0] tpc;
    int          fidx;
    int          post;
    int          gap;
    int          exp_count;
    logic [31:0] exp_first;
    bit          toggle;
  } vec_t;

  vec_t tbl [6];
  logic [79:0] q [$];
  int nvec = 0;
  int nerr = 0;

  function automatic logic [79:0] ent(input int i);
    logic [31:0] pc;
    pc = 32'(i * 4);
    return {16'(i) ^ 16'h5A00, pc ^ 32'hDEAD_0000, pc};
  endfunction

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_ent(input int i, input logic frc);
    valid_in   = 1'b1;
    pc_in      = ent(i)[31:0];
    alu_in     = ent(i)[63:32];
    ctrl_in    = ent(i)[79:64];
    force_trig = frc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    valid_in = 1'b0; force_trig = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("arm_state", 80'(state), 80'd1);
    chk("arm_count", 80'(count), 80'd0);
    chk("arm_trig", 80'(triggered), 80'd0);
  endtask

  task automatic readout(input bit toggle);
    int k = 0;
    while ((q.size() != 0 || rd_valid) && k < 64) begin
      rd_ready = toggle ? (k % 2 == 0) : 1'b1;
      if (q.size() == 0) begin
        chk("rd_extra", 80'(rd_valid), 80'd0);
        break;
      end
      chk("rd_valid", 80'(rd_valid), 80'd1);
      chk("rd_data", rd_data, q[0]);
      if (rd_ready) void'(q.pop_front());
      tick();
      k++;
    end
    rd_ready = 1'b0;
    chk("rd_end_valid", 80'(rd_valid), 80'd0);
    chk("rd_end_count", 80'(count), 80'd0);
    chk("rd_end_state", 80'(state), 80'd3);
  endtask

  task automatic run(input vec_t v);
    int  i = 0;
    int  rem = 0;
    bit  seen = 0;
    bit  done = 0;
    bit  hit;
    do_arm();
    q.delete();
    trig_en  = v.ten;
    trig_pc  = v.tpc;
    post_cnt = 3'(v.post);
    while (!done && i < 64) begin
      drive_ent(i, i == v.fidx);
      hit = force_trig || (trig_en && pc_in == trig_pc);
      tick();
      q.push_back(ent(i));
      if (q.size() > 8) void'(q.pop_front());
      if (!seen) begin
        if (hit) begin
          seen = 1;
          rem  = v.post;
          done = (rem == 0);
        end
      end else begin
        rem--;
        done = (rem == 0);
      end
      chk("cap_state", 80'(state), done ? 80'd3 : (seen ? 80'd2 : 80'd1));
      if (!done) chk("cap_rdv", 80'(rd_valid), 80'd0);
      valid_in = 1'b0;
      force_trig = 1'b0;
      i++;
      if (!done)
        repeat (v.gap) begin
          tick();
          chk("gap_state", 80'(state), seen ? 80'd2 : 80'd1);
        end
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL capture_timeout: got no trigger/tail after %0d entries", i);
    end
    trig_en = 1'b0;
    chk("done_count", 80'(count), 80'(v.exp_count));
    chk("done_trig", 80'(triggered), 80'd1);
    chk("done_first", 80'(rd_data[31:0]), 80'(v.exp_first));
    readout(v.toggle);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h20, -1, 2, 0, 8, 32'h0C, 1'b0};
    tbl[1] = '{1'b0, 32'h00,  2, 0, 0, 3, 32'h00, 1'b0};
    tbl[2] = '{1'b1, 32'h08, -1, 3, 2, 6, 32'h00, 1'b0};
    tbl[3] = '{1'b1, 32'h00, -1, 7, 0, 8, 32'h00, 1'b0};
    tbl[4] = '{1'b1, 32'h20, -1, 2, 0, 8, 32'h0C, 1'b1};
    tbl[5] = '{1'b1, 32'h40, -1, 5, 1, 8, 32'h38, 1'b1};

    #3;
    chk("rst_state", 80'(state), 80'd0);
    chk("rst_count", 80'(count), 80'd0);
    chk("rst_rdv", 80'(rd_valid), 80'd0);
    chk("rst_rdd", rd_data, 80'd0);
    chk("rst_trig", 80'(triggered), 80'd0);
    tick();
    rst_n = 1'b1;
    tick();

    do_arm();
    for (int i = 0; i < 5; i++) begin
      drive_ent(i, 1'b0);
      tick();
    end
    valid_in = 1'b0;
    chk("pre_rst_count", 80'(count), 80'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 80'(state), 80'd0);
    chk("midrst_count", 80'(count), 80'd0);
    chk("midrst_rdv", 80'(rd_valid), 80'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_ent(i, 1'b1);
      tick();
    end
    valid_in = 1'b0; force_trig = 1'b0;
    chk("idle_count", 80'(count), 80'd0);
    chk("idle_state", 80'(state), 80'd0);

    trig_en = 1'b1; trig_pc = 32'h10; post_cnt = 3'd0;
    drive_ent(4, 1'b0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("coin_state", 80'(state), 80'd1);
    chk("coin_trig", 80'(triggered), 80'd0);
    chk("coin_count", 80'(count), 80'd0);
    tick();
    valid_in = 1'b0; trig_en = 1'b0;
    chk("coin2_state", 80'(state), 80'd3);
    chk("coin2_count", 80'(count), 80'd1);
    chk("coin2_trig", 80'(triggered), 80'd1);
    q.delete();
    q.push_back(ent(4));
    readout(1'b0);

    for (int t = 0; t < 6; t++) run(tbl[t]);

    drive_ent(9, 1'b1);
    tick();
    valid_in = 1'b0; force_trig = 1'b0;
    chk("done_force_state", 80'(state), 80'd3);
    chk("done_force_count", 80'(count), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Parametrised, synthesizable trace-capture buffer for the single-cycle RISC-V core. It records one entry per retired instruction: PC, ALU result and a control-signal snapshot. Capture runs in a circular pre-trigger window, a programmable post-trigger tail follows, and the buffer then freezes for readout over a valid/ready port. It sits beside the datapath and takes the place of simulation-only printing, so a trace survives into FPGA builds.

## Interface
- XLEN, 32, width of the PC and ALU-result fields
- DEPTH, 16, number of entries; power of two, ≥ 4
- CTRL_W, 16, width of the control snapshot (pcsel, immsel, regwen, brun, asel, bsel, alusel, memrw, wbsel packed by the integrator)
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  an instruction retires this cycle; sample pc_in/alu_in/ctrl_in
- pc_in  in  XLEN  retiring PC
- alu_in  in  XLEN  ALU result
- ctrl_in  in  CTRL_W  control snapshot
- arm  in  1  pulse: clear the buffer and start capture
- trig_en  in  1  enable the PC-match trigger
- trig_pc  in  XLEN  PC to match
- force_trig  in  1  unconditional trigger, qualified by valid_in
- post_cnt  in  $clog2(DEPTH)  entries captured after the trigger entry; sampled at the trigger
- rd_ready  in  1  consumer accepts rd_data
- rd_valid  out  1  rd_data holds an unread entry
- rd_data  out  CTRL_W+2*XLEN  {ctrl, alu, pc} of the oldest unread entry
- count  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
- triggered  out  1  a trigger has been taken since the last arm

## Operation
- Storage is a register array of DEPTH entries, with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
- IDLE: no writes. On `arm`: go to ARMED and clear wr_ptr, count and triggered.
- ARMED: on valid_in, write the entry at wr_ptr, increment wr_ptr (wrapping) and increment count, saturating at DEPTH. Once full, the oldest entry is overwritten.
- Trigger condition: valid_in && (force_trig || (trig_en && pc_in == trig_pc)).
  - The trigger entry is always written and triggered is set.
  - If post_cnt == 0, go to DONE; otherwise load remain = post_cnt and go to POST.
- POST: each valid_in writes as in ARMED and decrements remain. The write that takes remain to 0 moves the block to DONE. Further triggers are ignored.
- DONE: no writes. On entry, rd_ptr = wr_ptr − count (mod DEPTH), which is the oldest entry.
  - rd_valid = (count ≠ 0), and rd_data = mem[rd_ptr].
  - Each rd_valid && rd_ready increments rd_ptr and decrements count.
  - When count reaches 0, rd_valid drops and the block stays in DONE.
- `arm` in ARMED, POST or DONE restarts capture as from IDLE and discards all contents. If arm and a trigger coincide, arm wins and the trigger is ignored.
- Trigger or force_trig in IDLE or DONE has no effect.
- rd_ready outside DONE is ignored and rd_valid is 0.

## Timing
- Reset (asynchronous, immediate): state IDLE, count 0, triggered 0, rd_valid 0, rd_data 0, all pointers 0. Array contents are don't-care and are never presented, because rd_valid is 0.
- Deassertion of rst_n takes effect at the next rising edge. Reset asserted mid-capture or mid-readout aborts to IDLE.
- arm is sampled at edge E; state reads ARMED after E. The first capture is the valid_in sampled at edge E+1.
- Trigger entry written at edge T:
  - post_cnt = 0: state is DONE after T.
  - Otherwise state is POST after T, and DONE after the post_cnt-th subsequent valid write.
- rd_valid and rd_data are combinational from registered state, so they are valid in the first DONE cycle. Zero-latency pop: a new entry is presented in the cycle after each accepted handshake.
- count updates at the same edge as the write or pop, saturating at DEPTH and never underflowing.
- Pointer wrap DEPTH−1 → 0 is seamless.

## Test plan
- Reset mid-ARMED with count 5 → immediately state 00, count 0, rd_valid 0. After release, no writes occur until arm.
- DEPTH=8, post_cnt=2, trig_en=1, trig_pc=0x20, with valid_in every cycle and pc = 0x00, 0x04, …:
  - Trigger on 0x20, DONE after 0x28, count 8.
  - Readout with rd_ready=1 yields pc 0x0C, 0x10, …, 0x28, and then rd_valid drops.
- force_trig on the 3rd valid entry with post_cnt=0 → DONE, count 3, reads return entries 1..3 in order, triggered=1.
- Readout with rd_ready toggling 1,0,1,0 → each entry is presented exactly once, rd_data holds while rd_ready is 0, and there are no duplicates or drops.
- arm in the same cycle as a PC match → state ARMED, triggered 0, count 0. The match in the next cycle triggers normally.
- post_cnt=3 with valid_in gaps of 2 cycles → remain decrements only on valid writes, and DONE comes exactly after the 3rd post-trigger write.
